// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing and PPU row-handshake generator.
// Runs on the system clock; an internal divider produces one pix_en strobe
// every CLK_DIV clocks. All outputs are registered and change on the pix_en clk.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            timing runs while high; low clears the raster to idle
//   pix_en            one-clk strobe per pixel
//   hs, vs            sync outputs, active level HS_POL / VS_POL
//   de                visible-pixel data enable
//   x, y              coordinates of the pixel currently presented
//   rowram_swap       one-clk pulse at the start of each new source row
//   next_row          source row the PPU renders next
//   vblank_start      one-clk pulse entering line V_ACTIVE
//   vblank_end_soon   one-clk pulse entering line V_TOTAL-PREFETCH_LINES
//   frame_cnt         completed frames, wraps
module video_timing_gen #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned SCALE          = 2,
    parameter int unsigned PREFETCH_LINES = 2,
    parameter bit          HS_POL         = 1'b0,
    parameter bit          VS_POL         = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned ROWS    = V_ACTIVE / SCALE,
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          pix_en,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          rowram_swap,
    output logic [RW-1:0] next_row,
    output logic          vblank_start,
    output logic          vblank_end_soon,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned VBES_Y   = V_TOTAL - PREFETCH_LINES;

    // Elaboration-time parameter sanity checks
    if (SCALE < 1 || (V_ACTIVE % SCALE) != 0) begin : g_bad_scale
        $error("video_timing_gen: V_ACTIVE must be a non-zero multiple of SCALE");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV must be >= 1");
    end
    // The upper bound excludes the line where vblank_start already fires.
    if (PREFETCH_LINES < 1 || PREFETCH_LINES >= V_FP + V_SYNC + V_BP) begin : g_bad_prefetch
        $error("video_timing_gen: PREFETCH_LINES out of range");
    end

    // h_cnt/v_cnt hold the position of the pixel that the next pix_en presents.
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    // Output line index within the current source row (0..SCALE-1).
    logic [SW-1:0] scale_cnt;

    logic tick_c;
    logic line_start_c;
    logic h_last_c;
    logic v_last_c;
    logic active_line_c;
    logic swap_c;
    logic vbs_c;
    logic vbes_c;
    logic frame_wrap_c;
    logic de_c;
    logic hs_act_c;
    logic vs_act_c;

    // Pixel strobe and raster decode for the pixel about to be presented
    assign tick_c        = enable && (32'(div_cnt) == CLK_DIV - 1);
    assign line_start_c  = tick_c && (h_cnt == '0);
    assign h_last_c      = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last_c      = (32'(v_cnt) == V_TOTAL - 1);
    assign active_line_c = (32'(v_cnt) < V_ACTIVE);
    assign swap_c        = line_start_c && active_line_c && (scale_cnt == '0);
    assign vbs_c         = line_start_c && (32'(v_cnt) == V_ACTIVE);
    assign vbes_c        = line_start_c && (32'(v_cnt) == VBES_Y);
    // A frame completes when (0,0) is presented right after the last line;
    // the first (0,0) after reset or re-enable is not a completed frame.
    assign frame_wrap_c  = line_start_c && (v_cnt == '0) && (32'(y) == V_TOTAL - 1);
    assign de_c          = (32'(h_cnt) < H_ACTIVE) && active_line_c;
    assign hs_act_c      = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    assign vs_act_c      = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);

    // Divider, raster counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt         <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            scale_cnt       <= '0;
            pix_en          <= 1'b0;
            hs              <= ~HS_POL;
            vs              <= ~VS_POL;
            de              <= 1'b0;
            x               <= '0;
            y               <= '0;
            rowram_swap     <= 1'b0;
            next_row        <= '0;
            vblank_start    <= 1'b0;
            vblank_end_soon <= 1'b0;
            frame_cnt       <= '0;
        end else if (!enable) begin
            // Idle: everything back to its start state except frame_cnt
            div_cnt         <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            scale_cnt       <= '0;
            pix_en          <= 1'b0;
            hs              <= ~HS_POL;
            vs              <= ~VS_POL;
            de              <= 1'b0;
            x               <= '0;
            y               <= '0;
            rowram_swap     <= 1'b0;
            next_row        <= '0;
            vblank_start    <= 1'b0;
            vblank_end_soon <= 1'b0;
        end else begin
            pix_en          <= tick_c;
            rowram_swap     <= swap_c;
            vblank_start    <= vbs_c;
            vblank_end_soon <= vbes_c;
            div_cnt         <= tick_c ? '0 : div_cnt + DW'(1);

            if (tick_c) begin
                x  <= h_cnt;
                y  <= v_cnt;
                de <= de_c;
                hs <= hs_act_c ? HS_POL : ~HS_POL;
                vs <= vs_act_c ? VS_POL : ~VS_POL;
                if (h_last_c) begin
                    h_cnt <= '0;
                    v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end

            // next_row walks 1..ROWS-1 then 0; it starts from 0 every frame
            if (swap_c) begin
                next_row <= (32'(next_row) == ROWS - 1) ? '0 : next_row + RW'(1);
            end else if (vbs_c) begin
                next_row <= '0;
            end

            if (line_start_c && active_line_c) begin
                scale_cnt <= (32'(scale_cnt) == SCALE - 1) ? '0 : scale_cnt + SW'(1);
            end

            if (frame_wrap_c) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
